// File: rtl/fifo_push_arbiter_pkg.sv
// Shared types and constants for the two-requester FIFO push arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

  // PUSH_FLAG code the FIFO macro reports when it has no free slot.
  localparam logic [3:0] PUSH_FLAG_FULL = 4'h0;

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// Bundle of the requester handshakes, flush control and FIFO push-side pins.
// The arbiter uses the slave modport; the producers/FIFO side uses master.
interface fifo_push_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);

  logic              A_Valid;
  logic [DATA_W-1:0] A_Data;
  logic              A_Ready;
  logic              B_Valid;
  logic [DATA_W-1:0] B_Data;
  logic              B_Ready;
  logic              Flush_Req;
  logic              Flush_Done;
  logic              Fifo_Push;
  logic [DATA_W-1:0] Fifo_Din;
  logic              Fifo_Push_Flush;
  logic              Fifo_Push_Clk_En;
  logic [3:0]        Push_Flag;
  logic              Almost_Full;
  logic [CNT_W-1:0]  A_Count;
  logic [CNT_W-1:0]  B_Count;

  modport master (
    output A_Valid, A_Data, B_Valid, B_Data, Flush_Req, Push_Flag, Almost_Full,
    input  A_Ready, B_Ready, Flush_Done, Fifo_Push, Fifo_Din, Fifo_Push_Flush,
           Fifo_Push_Clk_En, A_Count, B_Count
  );

  modport slave (
    input  A_Valid, A_Data, B_Valid, B_Data, Flush_Req, Push_Flag, Almost_Full,
    output A_Ready, B_Ready, Flush_Done, Fifo_Push, Fifo_Din, Fifo_Push_Flush,
           Fifo_Push_Clk_En, A_Count, B_Count
  );

endinterface

// File: rtl/fifo_push_arbiter_rr_arb2.sv
// Two-way round-robin grant. A lone valid requester always wins; when both
// are valid the pointer decides, and after every accept the pointer moves to
// the requester that did not win so the loser goes first next time.
module rr_arb2
  import fifo_arb_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_can_push,
  input  logic i_valid_a,
  input  logic i_valid_b,
  output logic o_ready_a,
  output logic o_ready_b
);

  req_e r_ptr;
  logic w_accept;

  // Grant is one-hot or idle; it needs a valid so both readies are never high together.
  always_comb begin
    o_ready_a = 1'b0;
    o_ready_b = 1'b0;
    if (i_can_push) begin
      if (i_valid_a && (!i_valid_b || r_ptr == REQ_A)) begin
        o_ready_a = 1'b1;
      end else if (i_valid_b) begin
        o_ready_b = 1'b1;
      end
    end
  end

  assign w_accept = (i_valid_a & o_ready_a) | (i_valid_b & o_ready_b);

  // Pointer hands priority to the non-winner, only when a word is actually taken.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= REQ_A;
    end else if (w_accept) begin
      r_ptr <= o_ready_a ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Shares one FIFO_16K_BLK push port between requesters A and B, throttles on
// the FIFO full/almost-full flags and sequences push-side flushes.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int FLUSH_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input logic                Sys_Clk,
  input logic                Sys_Rst_n,
  fifo_push_arbiter_if.slave bus
);

  localparam logic [1:0] ST_RUN     = RUN;
  localparam logic [1:0] ST_FLUSH   = FLUSH;
  localparam logic [1:0] ST_DONE    = DONE;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  logic [1:0]        r_state;
  logic [3:0]        r_flush_cnt;
  logic              r_last_slot;
  logic              r_push;
  logic [DATA_W-1:0] r_din;
  logic [CNT_W-1:0]  r_a_count;
  logic [CNT_W-1:0]  r_b_count;

  logic w_can_push;
  logic w_ready_a;
  logic w_ready_b;
  logic w_acc_a;
  logic w_acc_b;

  // Readies are held low during reset, outside RUN, on a full FIFO, after the
  // last free slot has been used, and in the cycle a flush is requested.
  assign w_can_push = Sys_Rst_n
                    & (r_state == ST_RUN)
                    & (bus.Push_Flag != PUSH_FLAG_FULL)
                    & ~(bus.Almost_Full & r_last_slot)
                    & ~bus.Flush_Req;

  rr_arb2 u_rr_arb2 (
    .i_clk      (Sys_Clk),
    .i_rst_n    (Sys_Rst_n),
    .i_can_push (w_can_push),
    .i_valid_a  (bus.A_Valid),
    .i_valid_b  (bus.B_Valid),
    .o_ready_a  (w_ready_a),
    .o_ready_b  (w_ready_b)
  );

  assign w_acc_a = bus.A_Valid & w_ready_a;
  assign w_acc_b = bus.B_Valid & w_ready_b;

  assign bus.A_Ready          = w_ready_a;
  assign bus.B_Ready          = w_ready_b;
  assign bus.Fifo_Push        = r_push;
  assign bus.Fifo_Din         = r_din;
  assign bus.Fifo_Push_Flush  = (r_state == ST_FLUSH);
  assign bus.Flush_Done       = (r_state == ST_DONE);
  assign bus.Fifo_Push_Clk_En = 1'b1;
  assign bus.A_Count          = r_a_count;
  assign bus.B_Count          = r_b_count;

  // Flush sequencer: RUN -> FLUSH for FLUSH_CYCLES cycles -> DONE for one cycle -> RUN.
  always_ff @(posedge Sys_Clk or negedge Sys_Rst_n) begin
    if (!Sys_Rst_n) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 4'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.Flush_Req) begin
            r_state     <= ST_FLUSH;
            r_flush_cnt <= FLUSH_LOAD;
          end
        end
        ST_FLUSH: begin
          if (r_flush_cnt == 4'd0) begin
            r_state <= ST_DONE;
          end else begin
            r_flush_cnt <= r_flush_cnt - 4'd1;
          end
        end
        ST_DONE: r_state <= ST_RUN;
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Almost_Full lags one push, so only one word may go into the final slot.
  always_ff @(posedge Sys_Clk or negedge Sys_Rst_n) begin
    if (!Sys_Rst_n) begin
      r_last_slot <= 1'b0;
    end else if (!bus.Almost_Full) begin
      r_last_slot <= 1'b0;
    end else if (w_acc_a | w_acc_b) begin
      r_last_slot <= 1'b1;
    end
  end

  // Accepted word reaches the FIFO push pins one cycle after the handshake.
  always_ff @(posedge Sys_Clk or negedge Sys_Rst_n) begin
    if (!Sys_Rst_n) begin
      r_push <= 1'b0;
      r_din  <= '0;
    end else begin
      r_push <= w_acc_a | w_acc_b;
      if (w_acc_a) begin
        r_din <= bus.A_Data;
      end else if (w_acc_b) begin
        r_din <= bus.B_Data;
      end
    end
  end

  // Per-requester accepted-word counters; they wrap and survive flushes.
  always_ff @(posedge Sys_Clk or negedge Sys_Rst_n) begin
    if (!Sys_Rst_n) begin
      r_a_count <= '0;
      r_b_count <= '0;
    end else begin
      if (w_acc_a) r_a_count <= r_a_count + 1'b1;
      if (w_acc_b) r_b_count <= r_b_count + 1'b1;
    end
  end

endmodule
